// File: rtl/instr_loader_rom_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_rom_if
// Description : Bundles the byte-wide program load stream and the core fetch
//               port of instr_loader_rom.
//               master : program source / core side
//                        (drives load_*, PC; observes status and Instruction)
//               slave  : instr_loader_rom itself
//               Signals:
//                 load_start  - one-cycle pulse, begins a new program load
//                 load_valid  - load_byte is valid
//                 load_byte   - program byte, little-endian within a word
//                 load_last   - final byte of the program (with load_valid)
//                 load_ready  - block accepts a byte this cycle
//                 load_done   - one-cycle pulse when a load finishes
//                 load_error  - sticky error flag
//                 word_count  - words written by the current or last load
//                 cpu_hold    - core must stall while high
//                 PC          - byte fetch address from the core
//                 Instruction - registered fetch data
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_loader_rom_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic                  load_error;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  cpu_hold;
    logic [31:0]           PC;
    logic [31:0]           Instruction;

    modport master (
        output load_start,
        output load_valid,
        output load_byte,
        output load_last,
        output PC,
        input  load_ready,
        input  load_done,
        input  load_error,
        input  word_count,
        input  cpu_hold,
        input  Instruction
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_byte,
        input  load_last,
        input  PC,
        output load_ready,
        output load_done,
        output load_error,
        output word_count,
        output cpu_hold,
        output Instruction
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader_rom.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_rom
// Description : Instruction-side responder for the pipelined ARM core.
//               Program bytes arrive over a valid/ready stream, are packed
//               little-endian into 32-bit words and stored in a word array.
//               The core is held until a load completes; afterwards PC
//               fetches return the stored words with one cycle of latency.
//               Ports:
//                 clk      - single clock, rising edge
//                 reset_n  - asynchronous active-low reset
//                 bus      - slave side of instr_loader_rom_if (load stream,
//                            status outputs, PC / Instruction fetch port)
//               Parameters:
//                 ADDR_WIDTH - word-address bits, depth = 2**ADDR_WIDTH;
//                              must equal the interface's ADDR_WIDTH
//                 NOP_WORD   - returned for held / out-of-range / unwritten
//                              fetches
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader_rom #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    instr_loader_rom_if.slave  bus
);

    localparam int             DEPTH      = 1 << ADDR_WIDTH;
    // word_count value meaning "array full"
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                state_q,      state_d;
    logic [1:0]            byte_cnt_q,   byte_cnt_d;
    logic [31:0]           acc_q,        acc_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  load_error_q, load_error_d;
    logic                  load_ready_q, load_ready_d;
    logic                  load_done_q,  load_done_d;
    logic                  cpu_hold_q,   cpu_hold_d;
    logic [31:0]           instr_q,      instr_d;

    // Program storage; deliberately not reset, word_count hides stale data
    logic [31:0]           mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           acc_merged;
    logic                  byte_accept;

    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  fetch_hi_zero;
    logic                  fetch_in_range;
    logic                  pc_unused;

    // ------------------------------------------------------------------
    // Byte packing: current accumulator with the incoming byte dropped
    // into its little-endian lane. Upper lanes stay zero because the
    // accumulator is cleared after every word write and on load entry.
    // ------------------------------------------------------------------
    always_comb begin
        acc_merged = acc_q;
        case (byte_cnt_q)
            2'd0:    acc_merged[7:0]   = bus.load_byte;
            2'd1:    acc_merged[15:8]  = bus.load_byte;
            2'd2:    acc_merged[23:16] = bus.load_byte;
            default: acc_merged[31:24] = bus.load_byte;
        endcase
    end

    // load_ready_q is only ever high in ST_LOAD
    assign byte_accept = bus.load_valid && load_ready_q;
    assign mem_waddr   = word_count_q[ADDR_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Fetch decode. PC[1:0] is a byte offset within the word and is
    // intentionally ignored.
    // ------------------------------------------------------------------
    assign fetch_idx      = bus.PC[ADDR_WIDTH+1:2];
    assign fetch_hi_zero  = (bus.PC[31:ADDR_WIDTH+2] == '0);
    assign fetch_in_range = ({1'b0, fetch_idx} < word_count_q);
    assign pc_unused      = ^bus.PC[1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        acc_d        = acc_q;
        word_count_d = word_count_q;
        load_error_d = load_error_q;
        load_ready_d = load_ready_q;
        load_done_d  = 1'b0;
        cpu_hold_d   = cpu_hold_q;
        mem_we       = 1'b0;

        case (state_q)
            ST_EMPTY, ST_RUN: begin
                // No byte can be accepted here (load_ready is low), so a
                // coincident load_valid is simply ignored.
                if (bus.load_start) begin
                    state_d      = ST_LOAD;
                    byte_cnt_d   = 2'd0;
                    acc_d        = 32'h0;
                    word_count_d = '0;
                    load_error_d = 1'b0;
                    load_ready_d = 1'b1;
                    cpu_hold_d   = 1'b1;
                end
            end

            ST_LOAD: begin
                // load_start is ignored while a load is in progress
                if (byte_accept) begin
                    if (word_count_q == FULL_COUNT) begin
                        // Overflow: byte is dropped, count saturates
                        load_error_d = 1'b1;
                    end else begin
                        if ((byte_cnt_q == 2'd3) || bus.load_last) begin
                            mem_we       = 1'b1;
                            word_count_d = word_count_q + 1'b1;
                            acc_d        = 32'h0;
                            // Program ended mid-word: store it zero-padded
                            // but flag the truncation
                            if (byte_cnt_q != 2'd3) begin
                                load_error_d = 1'b1;
                            end
                        end else begin
                            acc_d = acc_merged;
                        end
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end

                    if (bus.load_last) begin
                        state_d      = ST_RUN;
                        load_ready_d = 1'b0;
                        load_done_d  = 1'b1;
                        cpu_hold_d   = 1'b0;
                    end
                end
            end

            default: begin
                state_d      = ST_EMPTY;
                load_ready_d = 1'b0;
                cpu_hold_d   = 1'b1;
            end
        endcase

        // Fetch uses the currently registered hold and count, so a word
        // written at an edge is only visible to fetches at later edges.
        if (!cpu_hold_q && fetch_hi_zero && fetch_in_range) begin
            instr_d = mem[fetch_idx];
        end else begin
            instr_d = NOP_WORD;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            byte_cnt_q   <= 2'd0;
            acc_q        <= 32'h0;
            word_count_q <= '0;
            load_error_q <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            cpu_hold_q   <= 1'b1;
            instr_q      <= NOP_WORD;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            acc_q        <= acc_d;
            word_count_q <= word_count_d;
            load_error_q <= load_error_d;
            load_ready_q <= load_ready_d;
            load_done_q  <= load_done_d;
            cpu_hold_q   <= cpu_hold_d;
            instr_q      <= instr_d;
        end
    end

    // Word array write port; the final (possibly partial) word is the
    // merged accumulator including the byte accepted this cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= acc_merged;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.load_ready  = load_ready_q;
    assign bus.load_done   = load_done_q;
    assign bus.load_error  = load_error_q;
    assign bus.word_count  = word_count_q;
    assign bus.cpu_hold    = cpu_hold_q;
    assign bus.Instruction = instr_q;

endmodule
`default_nettype wire

// File: doc/instr_loader_rom.md
# instr_loader_rom

- Instruction-side responder for the pipelined ARM core: the core presents `PC` and this block returns `Instruction`.
- Program words arrive over a byte-wide valid/ready load stream, are packed little-endian into 32-bit words and written to an internal word array.
- The core is held (`cpu_hold`) until a load completes.
- Sits between the board-level program source (UART/camera-side loader) and the core's fetch port; instruction width and `PC` semantics match the existing core.

## Interface
Parameters:
- `ADDR_WIDTH`, 8 — word-address bits; depth = 2^ADDR_WIDTH words.
- `NOP_WORD`, 32'h0000_0000 — word returned for held, out-of-range or never-written fetches.

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `load_start` in 1 — one-cycle pulse; begins a new program load.
- `load_valid` in 1 — `load_byte` is valid.
- `load_byte` in 8 — program byte, little-endian within each word.
- `load_last` in 1 — qualifies the final byte of the program; sampled with `load_valid`.
- `load_ready` out 1 — block accepts a byte this cycle.
- `load_done` out 1 — one-cycle pulse when a load finishes.
- `load_error` out 1 — sticky error flag; cleared by `load_start` or reset.
- `word_count` out ADDR_WIDTH+1 — number of words written by the current or last load.
- `cpu_hold` out 1 — core must stall/stay in reset while high.
- `PC` in 32 — byte fetch address from the core.
- `Instruction` out 32 — registered fetch data.

## Operation
States:
- EMPTY: entered after reset. `cpu_hold`=1, `load_ready`=0.
- LOAD: `load_ready`=1, `cpu_hold`=1.
- RUN: `cpu_hold`=0, `load_ready`=0.

Transitions:
- EMPTY→LOAD and RUN→LOAD on `load_start`. Entering LOAD clears the byte counter (2 bits), `word_count`, `load_error` and the byte accumulator.
- `load_start` while in LOAD is ignored.
- LOAD→RUN on an accepted byte with `load_last`=1. `load_done` pulses in the cycle after that byte is accepted.

Byte acceptance (`load_valid && load_ready`):
- Byte k of a word (k=0..3) goes to bits 8k+7:8k.
- On the 4th byte the full word is written to address `word_count[ADDR_WIDTH-1:0]`, then `word_count` increments.

Last-byte and error rules:
- `load_last` on a non-4th byte: the partial word is zero-padded in its upper bytes and written, `word_count` increments, `load_error`=1.
- Overflow: a byte accepted while `word_count`==2^ADDR_WIDTH is discarded and `load_error`=1. The block stays in LOAD until `load_last`. `word_count` saturates at 2^ADDR_WIDTH.

Fetch:
- Word index = `PC[ADDR_WIDTH+1:2]`. `PC[1:0]` is ignored.
- `Instruction` = `NOP_WORD` when any of these holds: `cpu_hold`=1; `PC[31:ADDR_WIDTH+2]`≠0; word index ≥ `word_count`.
- Otherwise `Instruction` = stored word.
- Memory contents are not cleared by reset or `load_start`. The `word_count` gate hides stale words.

## Timing
- Reset values: state EMPTY, `Instruction`=`NOP_WORD`, `cpu_hold`=1, `load_ready`=0, `load_done`=0, `load_error`=0, `word_count`=0.
- Fetch latency is 1 cycle: `PC` sampled at edge n, `Instruction` valid after edge n.
- A word written at edge n is readable by a fetch sampled at edge n+1 or later (no write-through bypass).
- `load_ready` rises the cycle after `load_start` is sampled and falls the cycle after the `load_last` byte is accepted.
- `cpu_hold` falls in the same cycle `load_done` is high. The first non-NOP fetch is sampled on that cycle's closing edge.
- `load_valid` without `load_ready` has no effect; no byte is buffered.
- Reset mid-load: immediate return to EMPTY, all outputs to reset values. Partially written words remain in the array but are hidden (`word_count`=0).
- Simultaneous `load_start` and accepted byte in RUN: `load_start` wins. No byte is accepted in RUN, so none is lost.

## Test plan
- Reset → `cpu_hold`=1, `load_ready`=0, `Instruction`=0, `word_count`=0; `PC`=0 fetch during hold returns 0.
- Load bytes 01,00,81,E2, 01,10,43,E2 (`load_last` on 8th byte) → `word_count`=2, one `load_done` pulse, `cpu_hold` falls; `PC`=0 gives E2810001 one cycle later, `PC`=4 gives E2431001, `PC`=8 gives NOP.
- `ADDR_WIDTH`=2: load 20 bytes → first 16 stored, `word_count`=4, `load_error`=1; `PC`=12 returns the 4th word.
- Load 6 bytes AA,BB,CC,DD,11,22 with `load_last` on 6th → word1=0000_2211, `word_count`=2, `load_error`=1, state RUN.
- Assert `reset_n` low after 3 bytes of a load → `cpu_hold`=1, `word_count`=0; new load of 4 bytes works normally.
- In RUN, `PC`=32'h0000_1000 (`ADDR_WIDTH`=8) → NOP; second `load_start` → `cpu_hold`=1, `Instruction` NOP until the reload completes.
